spi_peripheral_sp3a: RTL and testbench

Responder end of the SP3A configuration SPI link. It is synthesizable and sits on the FPGA side as an SP3A chip emulator for loopback and bench work. It oversamples `spi_clk`/`cs_b`/`pico` on `axi_clk`, decodes the 12-bit opcode, and hands completed writes to an external register bank. For reads it serializes register data back on `poci`.

---
 rtl/spi_sp3a_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_peripheral_sp3a.sv | 197 +++++++++++++++++++
 tb/tb_spi_peripheral_sp3a.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sp3a_pkg.sv
// Shared constants and the FSM state type for the SP3A configuration SPI responder.
package spi_sp3a_pkg;

  localparam int OPCODE_BITS = 12;

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b00;

  localparam int CMD_MSB   = 11;
  localparam int CMD_LSB   = 10;
  localparam int GROUP_MSB = 9;
  localparam int GROUP_LSB = 8;
  localparam int ADDR_MSB  = 7;
  localparam int ADDR_LSB  = 0;

  // Cycles between reg_rd_en and reg_rdata being valid.
  localparam int RD_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_WDATA,
    ST_RDATA,
    ST_DISCARD,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, with registered rise/fall pulses.
module spi_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // [1:0] is the synchronizer proper; [2] is the previous synchronized level.
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_peripheral_sp3a.sv
// SP3A chip emulator: SPI mode-0 responder oversampled on axi_clk, decoding a 12-bit
// opcode and bridging writes/reads to an external register bank.
module spi_peripheral_sp3a
  import spi_sp3a_pkg::*;
#(
  parameter int MAX_DATA_BITS = 192
) (
  input  logic                     axi_clk,
  input  logic                     reset_b,
  input  logic                     spi_clk,
  input  logic                     cs_b,
  input  logic                     pico,
  output logic                     poci,
  output logic                     reg_wr_en,
  output logic                     reg_rd_en,
  output logic [1:0]               reg_group,
  output logic [7:0]               reg_addr,
  output logic [MAX_DATA_BITS-1:0] reg_wdata,
  output logic [7:0]               reg_wlen,
  input  logic [MAX_DATA_BITS-1:0] reg_rdata,
  output logic                     busy,
  output logic                     xfer_err
);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic cs_rise, cs_fall, cs_sync_unused;
  logic pico_s, pico_rise_unused, pico_fall_unused;

  spi_sync_edge u_sync_sclk (
    .clk_i  (axi_clk),
    .rst_n_i(reset_b),
    .d_i    (spi_clk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk_i  (axi_clk),
    .rst_n_i(reset_b),
    .d_i    (cs_b),
    .sync_o (cs_sync_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge u_sync_pico (
    .clk_i  (axi_clk),
    .rst_n_i(reset_b),
    .d_i    (pico),
    .sync_o (pico_s),
    .rise_o (pico_rise_unused),
    .fall_o (pico_fall_unused)
  );

  state_e                   state_q;
  logic [3:0]               op_cnt_q;
  logic [OPCODE_BITS-2:0]   opcode_q;
  logic [OPCODE_BITS-1:0]   opcode_d;
  logic [1:0]               group_q;
  logic [7:0]               addr_q;
  logic [MAX_DATA_BITS-1:0] wdata_q;
  logic [7:0]               wlen_q;
  logic                     ovf_q;
  logic [MAX_DATA_BITS-1:0] rd_shift_q;
  logic [1:0]               rd_wait_q;
  logic                     commit_wr_q;
  logic                     commit_err_q;
  logic                     poci_q;
  logic                     wr_en_q;
  logic                     rd_en_q;
  logic                     err_q;
  logic                     busy_q;

  // Full opcode including the bit arriving on this rise.
  assign opcode_d = {opcode_q, pico_s};

  always_ff @(posedge axi_clk) begin
    if (!reset_b) begin
      // NOTE: reg_wdata is a visible output register rather than a memory, so it is
      // cleared on reset along with everything else.
      state_q      <= ST_IDLE;
      op_cnt_q     <= '0;
      opcode_q     <= '0;
      group_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wlen_q       <= '0;
      ovf_q        <= 1'b0;
      rd_shift_q   <= '0;
      rd_wait_q    <= '0;
      commit_wr_q  <= 1'b0;
      commit_err_q <= 1'b0;
      poci_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;

      // The register bank answers a read request a fixed number of cycles later.
      if (rd_wait_q != 2'd0) begin
        rd_wait_q <= rd_wait_q - 2'd1;
        if (rd_wait_q == 2'd1) rd_shift_q <= reg_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          poci_q <= 1'b0;
          if (cs_fall) begin
            state_q  <= ST_OPCODE;
            busy_q   <= 1'b1;
            op_cnt_q <= '0;
            wlen_q   <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
          end
        end

        ST_COMMIT: begin
          wr_en_q <= commit_wr_q;
          err_q   <= commit_err_q;
          busy_q  <= 1'b0;
          poci_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          if (cs_rise) begin
            state_q      <= ST_COMMIT;
            poci_q       <= 1'b0;
            commit_wr_q  <= (state_q == ST_WDATA) && !ovf_q && (wlen_q != 8'd0);
            commit_err_q <= (state_q == ST_OPCODE) || (state_q == ST_DISCARD) ||
                            ((state_q == ST_WDATA) && ovf_q);
          end else begin
            case (state_q)
              ST_OPCODE: begin
                if (sclk_rise) begin
                  opcode_q <= opcode_d[OPCODE_BITS-2:0];
                  op_cnt_q <= op_cnt_q + 4'd1;
                  if (op_cnt_q == 4'(OPCODE_BITS - 1)) begin
                    group_q <= opcode_d[GROUP_MSB:GROUP_LSB];
                    addr_q  <= opcode_d[ADDR_MSB:ADDR_LSB];
                    if (opcode_d[CMD_MSB:CMD_LSB] == CMD_WRITE) begin
                      state_q <= ST_WDATA;
                    end else if (opcode_d[CMD_MSB:CMD_LSB] == CMD_READ) begin
                      rd_en_q   <= 1'b1;
                      rd_wait_q <= 2'(RD_LATENCY + 1);
                      state_q   <= ST_RDATA;
                    end else begin
                      state_q <= ST_DISCARD;
                    end
                  end
                end
              end

              ST_WDATA: begin
                if (sclk_rise) begin
                  if (wlen_q != 8'(MAX_DATA_BITS)) begin
                    wdata_q[wlen_q] <= pico_s;
                    wlen_q          <= wlen_q + 8'd1;
                  end else begin
                    ovf_q <= 1'b1;
                  end
                end
              end

              // Zeros shift in from the top, so poci reads 0 once the payload is exhausted.
              ST_RDATA: begin
                if (sclk_fall) begin
                  poci_q     <= rd_shift_q[0];
                  rd_shift_q <= rd_shift_q >> 1;
                end
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign poci      = poci_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_group = group_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wlen  = wlen_q;
  assign busy      = busy_q;
  assign xfer_err  = err_q;

endmodule

// File: tb/tb_spi_peripheral_sp3a.sv
// Self-checking bench for spi_peripheral_sp3a: a mode-0 SPI controller model with a
// write scoreboard and a poci bit scoreboard.
module tb_spi_peripheral_sp3a;

  localparam int W    = 192;
  localparam int CLK  = 10;
  localparam int HALF = 8 * CLK;

  logic         axi_clk = 1'b0;
  logic         reset_b = 1'b0;
  logic         spi_clk = 1'b0;
  logic         cs_b    = 1'b1;
  logic         pico    = 1'b0;
  logic         poci;
  logic         reg_wr_en, reg_rd_en;
  logic [1:0]   reg_group;
  logic [7:0]   reg_addr;
  logic [W-1:0] reg_wdata;
  logic [7:0]   reg_wlen;
  logic [W-1:0] reg_rdata = '0;
  logic         busy, xfer_err;

  spi_peripheral_sp3a #(.MAX_DATA_BITS(W)) dut (
    .axi_clk  (axi_clk),
    .reset_b  (reset_b),
    .spi_clk  (spi_clk),
    .cs_b     (cs_b),
    .pico     (pico),
    .poci     (poci),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_group(reg_group),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wlen (reg_wlen),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .xfer_err (xfer_err)
  );

  always #(CLK / 2) axi_clk = ~axi_clk;

  typedef struct packed {
    logic [1:0]   grp;
    logic [7:0]   addr;
    logic [7:0]   wlen;
    logic [W-1:0] wdata;
  } wr_exp_t;

  wr_exp_t      exp_q[$];
  logic         poci_exp_q[$];
  wr_exp_t      mon_e;
  logic [255:0] poci_cap;
  int           checks = 0;
  int           errors = 0;
  int           wr_pulses = 0;
  int           err_pulses = 0;
  int           rd_pulses = 0;

  // Write scoreboard: every commit strobe is matched against the oldest expected write.
  always @(negedge axi_clk) begin
    if (reg_wr_en) begin
      wr_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: grp=%0d addr=%h wlen=%0d, no write expected",
                 reg_group, reg_addr, reg_wlen);
      end else begin
        mon_e = exp_q.pop_front();
        if ({reg_group, reg_addr, reg_wlen, reg_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write_commit: got grp=%0d addr=%h wlen=%0d wdata=%h, want grp=%0d addr=%h wlen=%0d wdata=%h",
                   reg_group, reg_addr, reg_wlen, reg_wdata,
                   mon_e.grp, mon_e.addr, mon_e.wlen, mon_e.wdata);
        end
      end
    end
    if (xfer_err)  err_pulses++;
    if (reg_rd_en) rd_pulses++;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives nop opcode bits MSB first, then ndata payload bits LSB first. poci is
  // captured just before each payload rise. rst_at >= 0 pulses reset_b during that
  // payload bit's high phase.
  task automatic send_frame(input logic [11:0] op, input int nop,
                            input logic [255:0] data, input int ndata, input int rst_at);
    logic b;
    @(negedge axi_clk);
    cs_b = 1'b0;
    #(HALF);
    for (int i = 0; i < nop + ndata; i++) begin
      if (i < nop) b = op[11 - i];
      else         b = data[i - nop];
      pico = b;
      #(HALF);
      if (i >= nop) poci_cap[i - nop] = poci;
      spi_clk = 1'b1;
      if (i >= nop && (i - nop) == rst_at) begin
        @(negedge axi_clk);
        reset_b = 1'b0;
        @(negedge axi_clk);
        reset_b = 1'b1;
      end
      #(HALF);
      spi_clk = 1'b0;
    end
    #(HALF);
    cs_b = 1'b1;
    pico = 1'b0;
    #(20 * CLK);
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    repeat (4) @(negedge axi_clk);
    checks++;
    if ({poci, reg_wr_en, reg_rd_en, busy, xfer_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, want 00000", {poci, reg_wr_en, reg_rd_en, busy, xfer_err});
    end
    checks++;
    if ({reg_group, reg_addr, reg_wlen} !== 18'b0) begin
      errors++;
      $display("FAIL reset_fields: got grp=%0d addr=%h wlen=%0d, want 0", reg_group, reg_addr, reg_wlen);
    end
    checks++;
    if (reg_wdata !== '0) begin
      errors++;
      $display("FAIL reset_wdata: got %h, want 0", reg_wdata);
    end
    reset_b = 1'b1;
    repeat (10) @(negedge axi_clk);
  endtask

  task automatic test_write_short;
    int w0 = wr_pulses, e0 = err_pulses;
    exp_q.push_back('{grp: 2'd1, addr: 8'h0A, wlen: 8'd14, wdata: W'('h308F)});
    send_frame({2'b01, 2'b01, 8'h0A}, 12, 256'h308F, 14, -1);
    checks++;
    if (wr_pulses - w0 !== 1) begin
      errors++;
      $display("FAIL write14_pulses: got %0d, want 1", wr_pulses - w0);
    end
    checks++;
    if (err_pulses - e0 !== 0) begin
      errors++;
      $display("FAIL write14_err: got %0d, want 0", err_pulses - e0);
    end
    checks++;
    if (busy !== 1'b0 || reg_wlen !== 8'd14 || reg_addr !== 8'h0A) begin
      errors++;
      $display("FAIL write14_hold: got busy=%b wlen=%0d addr=%h, want 0/14/0a", busy, reg_wlen, reg_addr);
    end
  endtask

  task automatic test_write_full;
    int w0 = wr_pulses, e0 = err_pulses;
    exp_q.push_back('{grp: 2'd2, addr: 8'h00, wlen: 8'd192, wdata: W'('h3332AA)});
    send_frame({2'b01, 2'b10, 8'h00}, 12, 256'h3332AA, 192, -1);
    checks++;
    if (wr_pulses - w0 !== 1 || err_pulses - e0 !== 0) begin
      errors++;
      $display("FAIL write192: got wr=%0d err=%0d, want 1/0", wr_pulses - w0, err_pulses - e0);
    end
  endtask

  task automatic test_read;
    int r0 = rd_pulses, w0 = wr_pulses, e0 = err_pulses;
    logic exp_bit;
    reg_rdata = W'('h308F);
    for (int i = 0; i < 14; i++) poci_exp_q.push_back(reg_rdata[i]);
    send_frame({2'b00, 2'b01, 8'h0A}, 12, '0, 14, -1);
    for (int i = 0; i < 14; i++) begin
      exp_bit = poci_exp_q.pop_front();
      checks++;
      if (poci_cap[i] !== exp_bit) begin
        errors++;
        $display("FAIL read_poci_bit%0d: got %b, want %b", i, poci_cap[i], exp_bit);
      end
    end
    checks++;
    if (rd_pulses - r0 !== 1 || wr_pulses - w0 !== 0 || err_pulses - e0 !== 0) begin
      errors++;
      $display("FAIL read_strobes: got rd=%0d wr=%0d err=%0d, want 1/0/0",
               rd_pulses - r0, wr_pulses - w0, err_pulses - e0);
    end
    checks++;
    if (poci !== 1'b0 || reg_group !== 2'd1 || reg_addr !== 8'h0A) begin
      errors++;
      $display("FAIL read_after: got poci=%b grp=%0d addr=%h, want 0/1/0a", poci, reg_group, reg_addr);
    end
    reg_rdata = '0;
  endtask

  task automatic test_short_opcode;
    int w0 = wr_pulses, e0 = err_pulses;
    send_frame({2'b01, 2'b01, 8'h0A}, 7, '0, 0, -1);
    checks++;
    if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_opcode: got err=%0d wr=%0d busy=%b, want 1/0/0",
               err_pulses - e0, wr_pulses - w0, busy);
    end
  endtask

  task automatic test_zero_len;
    int w0 = wr_pulses, e0 = err_pulses;
    send_frame({2'b01, 2'b11, 8'h55}, 12, '0, 0, -1);
    checks++;
    if (err_pulses - e0 !== 0 || wr_pulses - w0 !== 0 || reg_wlen !== 8'd0) begin
      errors++;
      $display("FAIL zero_len: got err=%0d wr=%0d wlen=%0d, want 0/0/0",
               err_pulses - e0, wr_pulses - w0, reg_wlen);
    end
  endtask

  task automatic test_discard;
    int w0 = wr_pulses, e0 = err_pulses;
    send_frame({2'b10, 2'b01, 8'h33}, 12, 256'h1F, 5, -1);
    checks++;
    if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0) begin
      errors++;
      $display("FAIL discard: got err=%0d wr=%0d, want 1/0", err_pulses - e0, wr_pulses - w0);
    end
  endtask

  task automatic test_overflow;
    int w0 = wr_pulses, e0 = err_pulses;
    logic [255:0] stim;
    for (int i = 0; i < 8; i++) stim[i*32 +: 32] = $urandom;
    send_frame({2'b01, 2'b00, 8'h7E}, 12, stim, 200, -1);
    checks++;
    if (reg_wlen !== 8'd192) begin
      errors++;
      $display("FAIL overflow_wlen: got %0d, want 192", reg_wlen);
    end
    checks++;
    if (reg_wdata !== stim[W-1:0]) begin
      errors++;
      $display("FAIL overflow_wdata: got %h, want %h", reg_wdata, stim[W-1:0]);
    end
    checks++;
    if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0) begin
      errors++;
      $display("FAIL overflow_strobes: got err=%0d wr=%0d, want 1/0", err_pulses - e0, wr_pulses - w0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int w0 = wr_pulses, e0 = err_pulses, r0 = rd_pulses;
    send_frame({2'b01, 2'b01, 8'hC3}, 12, 256'h2A5B, 14, 5);
    checks++;
    if (wr_pulses - w0 !== 0 || err_pulses - e0 !== 0 || rd_pulses - r0 !== 0) begin
      errors++;
      $display("FAIL midreset_strobes: got wr=%0d err=%0d rd=%0d, want 0/0/0",
               wr_pulses - w0, err_pulses - e0, rd_pulses - r0);
    end
    checks++;
    if ({poci, busy, reg_group, reg_addr, reg_wlen} !== 20'b0 || reg_wdata !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got poci=%b busy=%b grp=%0d addr=%h wlen=%0d wdata=%h, want all 0",
               poci, busy, reg_group, reg_addr, reg_wlen, reg_wdata);
    end
    exp_q.push_back('{grp: 2'd3, addr: 8'h5C, wlen: 8'd9, wdata: W'('h1A5)});
    send_frame({2'b01, 2'b11, 8'h5C}, 12, 256'h1A5, 9, -1);
    checks++;
    if (wr_pulses - w0 !== 1 || err_pulses - e0 !== 0) begin
      errors++;
      $display("FAIL midreset_recovery: got wr=%0d err=%0d, want 1/0", wr_pulses - w0, err_pulses - e0);
    end
  endtask

  task automatic test_back_to_back;
    int w0 = wr_pulses;
    exp_q.push_back('{grp: 2'd0, addr: 8'h11, wlen: 8'd3, wdata: W'('h5)});
    exp_q.push_back('{grp: 2'd1, addr: 8'hEE, wlen: 8'd8, wdata: W'('hC9)});
    send_frame({2'b01, 2'b00, 8'h11}, 12, 256'h5, 3, -1);
    send_frame({2'b01, 2'b01, 8'hEE}, 12, 256'hC9, 8, -1);
    checks++;
    if (wr_pulses - w0 !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL back_to_back: got wr=%0d pending=%0d, want 2/0", wr_pulses - w0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_short();
    test_write_full();
    test_read();
    test_short_opcode();
    test_zero_len();
    test_discard();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
